// File: rtl/instruction_fetch.sv
// instruction_fetch: ternary-core fetch stage; PC, imem request/ready handshake, decode valid/ready handoff, illegal-trit rejection.
// Ports: clk/rst_n (async active-low); imem_req/imem_addr/imem_ready/imem_rdata to instruction memory;
// redirect_valid/redirect_addr from execute; instr_valid/instr_ready/instruction/instr_pc to decode; fetch_error sticky flag.
module instruction_fetch #(
  parameter int WORD_SIZE = 9,
  parameter int ADDR_SIZE = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [2*ADDR_SIZE-1:0] imem_addr,
  input  logic                   imem_ready,
  input  logic [2*WORD_SIZE-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [2*ADDR_SIZE-1:0] redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [2*WORD_SIZE-1:0] instruction,
  output logic [2*ADDR_SIZE-1:0] instr_pc,
  output logic                   fetch_error
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;
  logic [1:0]             r_state;
  logic [2*ADDR_SIZE-1:0] r_pc;
  logic [2*ADDR_SIZE-1:0] r_instr_pc;
  logic [2*WORD_SIZE-1:0] r_instr;
  logic                   r_err;
  logic [2*ADDR_SIZE-1:0] w_pc_inc;
  logic                   w_carry;
  logic                   w_illegal;
  // Balanced-ternary +1: a +1 trit rolls to -1 and keeps carrying; carry out of the top trit is dropped.
  always_comb begin
    w_pc_inc = r_pc;
    w_carry  = 1'b1;
    for (int i = 0; i < ADDR_SIZE; i++) begin
      if (w_carry) begin
        w_pc_inc[2*i+:2] = r_pc[2*i+:2] == 2'b01 ? 2'b11 : r_pc[2*i+:2] == 2'b11 ? 2'b00 : 2'b01;
        w_carry          = r_pc[2*i+:2] == 2'b01;
      end
    end
  end
  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) w_illegal = w_illegal | (imem_rdata[2*i+:2] == 2'b10);
  end
  // Redirect outranks everything: a held word or a word returned this cycle is dropped unchecked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_err      <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= redirect_addr;
      r_state <= S_FETCH;
      if (r_state == S_ERROR) r_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_state <= S_FETCH;
    end else if (r_state == S_FETCH && imem_ready && w_illegal) begin
      r_err   <= 1'b1;
      r_state <= S_ERROR;
    end else if (r_state == S_FETCH && imem_ready) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_pc;
      r_pc       <= w_pc_inc;
      r_err      <= 1'b0;
      r_state    <= S_HOLD;
    end else if (r_state == S_HOLD && instr_ready) begin
      r_state <= S_FETCH;
    end
  end
  assign imem_req    = r_state == S_FETCH;
  assign imem_addr   = r_pc;
  assign instr_valid = r_state == S_HOLD;
  assign instruction = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_error = r_err;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus hand-written error/reset sequences for instruction_fetch.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [17:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [17:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [17:0] redirect_addr = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [17:0] instruction;
  logic [17:0] instr_pc;
  logic        fetch_error;
  int checks = 0;
  int errors = 0;
  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc), .fetch_error(fetch_error)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        imr;
    logic [17:0] rd;
    logic        rv;
    logic [17:0] ra;
    logic        ir;
    logic        e_req;
    logic [17:0] e_addr;
    logic        e_val;
    logic [17:0] e_ins;
    logic [17:0] e_pc;
    logic        e_err;
  } vec_t;
  vec_t vecs[$];
  localparam logic [17:0] ALLP = 18'h15555;
  localparam logic [17:0] ALLM = 18'h3FFFF;
  localparam logic [17:0] W1 = 18'h00005, W2 = 18'h0F0F0, W3 = 18'h3FFFF, W4 = 18'h15555;
  localparam logic [17:0] W5 = 18'h0C3C3, W6 = 18'h30001, W8 = 18'h0000D, W9 = 18'h00001;
  localparam logic [17:0] BAD_LO = 18'h00080, BAD_HI = 18'h20000;
  localparam logic [17:0] RDIR = 18'h00007, RDIR2 = 18'h00010;
  function automatic vec_t mk(logic imr, logic [17:0] rd, logic rv, logic [17:0] ra, logic ir,
                              logic e_req, logic [17:0] e_addr, logic e_val, logic [17:0] e_ins,
                              logic [17:0] e_pc, logic e_err);
    vec_t v;
    v.imr = imr; v.rd = rd; v.rv = rv; v.ra = ra; v.ir = ir;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_ins = e_ins; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction
  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input logic e_req, input logic [17:0] e_addr, input logic e_val,
                         input logic [17:0] e_ins, input logic [17:0] e_pc, input logic e_err);
    chk({tag, ".imem_req"}, {17'd0, imem_req}, {17'd0, e_req});
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".instr_valid"}, {17'd0, instr_valid}, {17'd0, e_val});
    chk({tag, ".instruction"}, instruction, e_ins);
    chk({tag, ".instr_pc"}, instr_pc, e_pc);
    chk({tag, ".fetch_error"}, {17'd0, fetch_error}, {17'd0, e_err});
  endtask
  task automatic drive(input logic imr, input logic [17:0] rd, input logic rv, input logic [17:0] ra, input logic ir);
    imem_ready = imr; imem_rdata = rd; redirect_valid = rv; redirect_addr = ra; instr_ready = ir;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // Zero-wait run from reset: addresses 0, +1, (+1)(-1), (+1)0, then (+1)(+1).
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, 18'h0,     0, 0,  0,     0));
    vecs.push_back(mk(1, W1,     0, 0,    1, 0, 18'h1,     1, W1, 18'h0, 0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, 18'h1,     0, W1, 18'h0, 0));
    vecs.push_back(mk(1, W2,     0, 0,    1, 0, 18'h7,     1, W2, 18'h1, 0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, 18'h7,     0, W2, 18'h1, 0));
    vecs.push_back(mk(1, W3,     0, 0,    1, 0, 18'h4,     1, W3, 18'h7, 0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, 18'h4,     0, W3, 18'h7, 0));
    vecs.push_back(mk(1, W4,     0, 0,    1, 0, 18'h5,     1, W4, 18'h4, 0));
    // Redirect in HOLD with instr_ready also high: held word dropped, fetch from all-(+1).
    vecs.push_back(mk(0, 0,      1, ALLP, 1, 1, ALLP,      0, W4, 18'h4, 0));
    vecs.push_back(mk(1, W5,     0, 0,    1, 0, ALLM,      1, W5, ALLP,  0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, ALLM,      0, W5, ALLP,  0));
    vecs.push_back(mk(1, W6,     0, 0,    1, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    // Backpressure: 5 cycles held, a stray illegal word on imem_rdata must be ignored.
    vecs.push_back(mk(0, 0,      0, 0,    0, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    vecs.push_back(mk(1, BAD_HI, 0, 0,    0, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    vecs.push_back(mk(0, 0,      0, 0,    0, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    vecs.push_back(mk(0, 0,      0, 0,    0, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    vecs.push_back(mk(0, 0,      0, 0,    0, 0, 18'h3FFFC, 1, W6, ALLM,  0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, 18'h3FFFC, 0, W6, ALLM,  0));
    // Redirect in FETCH with imem_ready: returned (illegal) word dropped without an error.
    vecs.push_back(mk(1, BAD_LO, 1, RDIR, 1, 1, RDIR,      0, W6, ALLM,  0));
    vecs.push_back(mk(0, 0,      0, 0,    1, 1, RDIR,      0, W6, ALLM,  0));
    vecs.push_back(mk(1, BAD_LO, 0, 0,    1, 0, RDIR,      0, W6, ALLM,  1));
    rst_n = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      drive(vecs[k].imr, vecs[k].rd, vecs[k].rv, vecs[k].ra, vecs[k].ir);
      step();
      chk_all($sformatf("vec%0d", k), vecs[k].e_req, vecs[k].e_addr, vecs[k].e_val,
              vecs[k].e_ins, vecs[k].e_pc, vecs[k].e_err);
    end
    // ERROR holds for 10 cycles regardless of memory and decode activity.
    for (int c = 0; c < 10; c++) begin
      drive(c[0], W9, 0, 0, 1);
      step();
      chk_all($sformatf("err_hold%0d", c), 0, RDIR, 0, W6, ALLM, 1);
    end
    drive(0, 0, 1, RDIR2, 0);
    step();
    chk_all("err_redirect", 1, RDIR2, 0, W6, ALLM, 0);
    drive(1, W8, 0, 0, 0);
    step();
    chk_all("resume", 0, 18'h00011, 1, W8, RDIR2, 0);
    drive(0, 0, 0, 0, 1);
    step();
    chk_all("refetch", 1, 18'h00011, 0, W8, RDIR2, 0);
    // Asynchronous reset mid-FETCH with a word pending.
    drive(1, W9, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    step();
    chk_all("post_rst_fetch", 1, 0, 0, 0, 0, 0);
    drive(1, W1, 0, 0, 1);
    step();
    chk_all("post_rst_hold", 0, 18'h1, 1, W1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
